booth_seq_mult: RTL

Sequential radix-4 modified-Booth signed multiplier controller for the wordlib8 multiplier path. It time-shares a single Booth encoder/partial-product selector stage across WIDTH/2 iterations. Each cycle it feeds the stage one overlapping multiplier triplet and accumulates the shifted partial product. Operands enter and results leave through valid/ready handshakes.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_pp_sel.sv | 29 ++
 rtl/booth_seq_mult.sv | 97 +++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing for the sequential radix-4 Booth multiplier.
package booth_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int ITER      = DEF_WIDTH / 2;

  // Counter width for a given iteration count, never narrower than one bit.
  function automatic int cnt_bits(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  localparam int CNT_W = cnt_bits(ITER);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth encoder and partial-product selector for one multiplier triplet.
module booth_pp_sel #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]         triplet,
  input  logic [2*WIDTH-1:0] mcand,
  output logic               single,
  output logic               double,
  output logic               neg,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] mag;

  assign single = triplet[0] ^ triplet[1];
  assign double = (triplet[2] ^ triplet[0]) & ~single;
  assign neg    = triplet[2];

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    mag = '0;
    if (single)      mag = mcand;
    else if (double) mag = mcand << 1;
  end

  // Triplet 111 negates zero; ~0 + 1 wraps back to 0 in 2*WIDTH bits.
  assign pp = neg ? (~mag + 1'b1) : mag;

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth signed multiplier: one triplet per cycle, valid/ready in and out.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int NUM_ITER = WIDTH / 2;
  localparam int CNT_BITS = cnt_bits(NUM_ITER);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NUM_ITER - 1);

  state_t               state;
  logic [CNT_BITS-1:0]  count;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH:0]       y;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   sum;
  logic                 sel_single;
  logic                 sel_double;
  logic                 sel_neg;
  logic                 unused_sel;
  logic                 accept;

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .triplet (y[2:0]),
    .mcand   (mcand),
    .single  (sel_single),
    .double  (sel_double),
    .neg     (sel_neg),
    .pp      (pp)
  );

  assign unused_sel = sel_single ^ sel_double ^ sel_neg;

  // mcand is pre-shifted by 2 each iteration, so pp already carries the 2i weight.
  assign sum      = acc + pp;
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: all datapath registers are reset; an aborted run must leave nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      y         <= '0;
      acc       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= RUN;
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 2;
          y     <= {{2{y[WIDTH]}}, y[WIDTH:2]};
          count <= count + 1'b1;
          if (count == LAST) begin
            product   <= sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Operand capture overrides the per-state updates; it never coincides with RUN.
      if (accept) begin
        mcand <= {{WIDTH{a[WIDTH-1]}}, a};
        y     <= {b, 1'b0};
        acc   <= '0;
        count <= '0;
      end
    end
  end

endmodule
